// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: one programmable step timer drives
// blink-all, running-light, ping-pong and user-pattern alternation on LED_NUM outputs.
module led_pattern_gen #(
  parameter int LED_NUM = 8,
  parameter int MCNT    = 24_999_999
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic [1:0]         Mode,
  input  logic [LED_NUM-1:0] Pattern,
  output logic [LED_NUM-1:0] Led,
  output logic               Tick
);

  // A degenerate MCNT of 0 still needs a one-bit counter.
  localparam int CW = (MCNT > 0) ? $clog2(MCNT + 1) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(MCNT);
  localparam logic [LED_NUM-1:0] ONE_HOT_LSB = LED_NUM'(1);

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_USER  = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e         mode;
    logic          dir;
    logic          phase;
    logic [CW-1:0] cnt;
  } dbg_t;

  // Handshake: there is none; En is a level enable sampled every edge and
  // Tick is a one-cycle strobe coinciding with the first cycle of a new Led value.

  logic [CW-1:0]      cnt_q, cnt_d;
  mode_e              mode_q, mode_d;
  logic               dir_q, dir_d;
  logic               phase_q, phase_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               tick_q, tick_d;

  logic               mode_chg;
  logic               term;
  logic [LED_NUM-1:0] init_led;
  logic [LED_NUM-1:0] step_led;
  logic               step_dir;
  logic               step_phase;
  dbg_t               dbg_state;

  assign mode_chg = (Mode != mode_q);
  assign term     = (cnt_q == CNT_TERM);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      mode_q  <= MODE_BLINK;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  // Value loaded when a new mode is selected.
  always_comb begin
    init_led = '0;
    case (mode_e'(Mode))
      MODE_BLINK: init_led = '0;
      MODE_RUN:   init_led = ONE_HOT_LSB;
      MODE_PING:  init_led = ONE_HOT_LSB;
      MODE_USER:  init_led = Pattern;
      default:    init_led = '0;
    endcase
  end

  // Value produced by one step in the current mode.
  always_comb begin
    step_led   = led_q;
    step_dir   = dir_q;
    step_phase = phase_q;
    case (mode_q)
      MODE_BLINK: step_led = ~led_q;
      MODE_RUN:   step_led = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
      MODE_PING: begin
        // Turning around at an end moves away immediately, so each end
        // position is shown for exactly one step.
        if (!dir_q) begin
          if (led_q[LED_NUM-1]) begin
            step_dir = 1'b1;
            step_led = {1'b0, led_q[LED_NUM-1:1]};
          end else begin
            step_led = {led_q[LED_NUM-2:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            step_dir = 1'b0;
            step_led = {led_q[LED_NUM-2:0], 1'b0};
          end else begin
            step_led = {1'b0, led_q[LED_NUM-1:1]};
          end
        end
      end
      MODE_USER: begin
        step_phase = ~phase_q;
        step_led   = step_phase ? ~Pattern : Pattern;
      end
      default: step_led = led_q;
    endcase
  end

  // Next-state: mode change beats step, step beats hold.
  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    if (mode_chg) begin
      mode_d  = mode_e'(Mode);
      cnt_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
      led_d   = init_led;
    end else if (En) begin
      if (term) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        led_d   = step_led;
        dir_d   = step_dir;
        phase_d = step_phase;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Led = led_q;
    Tick = tick_q;
    dbg_state = '{mode: mode_q, dir: dir_q, phase: phase_q, cnt: cnt_q};
  end

  a_cnt_range : assert property (@(posedge Clk) disable iff (Reset)
    dbg_state.cnt <= CNT_TERM);

  a_onehot : assert property (@(posedge Clk) disable iff (Reset)
    (dbg_state.mode == MODE_RUN || dbg_state.mode == MODE_PING) |-> $onehot(led_q));

  a_dir_blink : assert property (@(posedge Clk) disable iff (Reset)
    (dbg_state.mode != MODE_PING) |-> !dbg_state.dir);

  generate
    if (MCNT >= 1) begin : g_tick_chk
      a_tick_single : assert property (@(posedge Clk) disable iff (Reset)
        tick_q |=> !tick_q);
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_NUM=8 and a 5-cycle step (MCNT=4).
module tb_led_pattern_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic [7:0] Pattern = 8'h00;
  logic [7:0] Led;
  logic       Tick;

  int total = 0;
  int bad = 0;

  logic [7:0] run_tab [0:8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] ping_tab [0:15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  led_pattern_gen #(.LED_NUM(8), .MCNT(4)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Mode    (Mode),
    .Pattern (Pattern),
    .Led     (Led),
    .Tick    (Tick)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, leaving time just past the last edge.
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    Reset = 1'b1;
    Mode = m;
    En = 1'b1;
    edges(1);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Mode = 2'd2;
    En = 1'b1;
    edges(2);
    total++;
    if (Led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", Led); end
    total++;
    if (Tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", Tick); end
  endtask

  task automatic test_blink;
    logic [7:0] exp_led;
    logic       exp_tick;
    do_reset(2'd0);
    for (int k = 1; k <= 15; k++) begin
      edges(1);
      exp_led = (((k / 5) % 2) == 1) ? 8'hFF : 8'h00;
      exp_tick = ((k % 5) == 0);
      total++;
      if (Led !== exp_led) begin bad++; $display("FAIL blink_led edge%0d got=%h exp=%h", k, Led, exp_led); end
      total++;
      if (Tick !== exp_tick) begin bad++; $display("FAIL blink_tick edge%0d got=%b exp=%b", k, Tick, exp_tick); end
    end
  endtask

  task automatic test_running;
    do_reset(2'd1);
    edges(1);
    total++;
    if (Led !== 8'h01) begin bad++; $display("FAIL run_init got=%h exp=01", Led); end
    for (int s = 0; s < 9; s++) begin
      edges(4);
      total++;
      if (Tick !== 1'b0) begin bad++; $display("FAIL run_idle_tick step%0d got=%b exp=0", s, Tick); end
      edges(1);
      total++;
      if (Led !== run_tab[s]) begin bad++; $display("FAIL run_led step%0d got=%h exp=%h", s, Led, run_tab[s]); end
      total++;
      if (Tick !== 1'b1) begin bad++; $display("FAIL run_tick step%0d got=%b exp=1", s, Tick); end
    end
  endtask

  task automatic test_pingpong;
    do_reset(2'd2);
    edges(1);
    total++;
    if (Led !== 8'h01) begin bad++; $display("FAIL ping_init got=%h exp=01", Led); end
    for (int s = 0; s < 16; s++) begin
      edges(5);
      total++;
      if (Led !== ping_tab[s]) begin bad++; $display("FAIL ping_led step%0d got=%h exp=%h", s, Led, ping_tab[s]); end
      total++;
      if (Tick !== 1'b1) begin bad++; $display("FAIL ping_tick step%0d got=%b exp=1", s, Tick); end
    end
  endtask

  task automatic test_user;
    Pattern = 8'hA5;
    do_reset(2'd3);
    edges(1);
    total++;
    if (Led !== 8'hA5) begin bad++; $display("FAIL user_init got=%h exp=a5", Led); end
    edges(5);
    total++;
    if (Led !== 8'h5A) begin bad++; $display("FAIL user_s1 got=%h exp=5a", Led); end
    edges(5);
    total++;
    if (Led !== 8'hA5) begin bad++; $display("FAIL user_s2 got=%h exp=a5", Led); end
    edges(5);
    total++;
    if (Led !== 8'h5A) begin bad++; $display("FAIL user_s3 got=%h exp=5a", Led); end
    edges(2);
    Pattern = 8'h0F;
    edges(1);
    total++;
    if (Led !== 8'h5A) begin bad++; $display("FAIL user_midstep got=%h exp=5a", Led); end
    edges(2);
    total++;
    if (Led !== 8'h0F) begin bad++; $display("FAIL user_s4 got=%h exp=0f", Led); end
    total++;
    if (Tick !== 1'b1) begin bad++; $display("FAIL user_s4_tick got=%b exp=1", Tick); end
    edges(5);
    total++;
    if (Led !== 8'hF0) begin bad++; $display("FAIL user_s5 got=%h exp=f0", Led); end
  endtask

  task automatic test_pause;
    do_reset(2'd0);
    edges(2);
    En = 1'b0;
    for (int k = 0; k < 12; k++) begin
      edges(1);
      total++;
      if (Led !== 8'h00 || Tick !== 1'b0) begin
        bad++; $display("FAIL pause_hold cyc%0d got=%h/%b exp=00/0", k, Led, Tick);
      end
    end
    En = 1'b1;
    edges(2);
    total++;
    if (Led !== 8'h00 || Tick !== 1'b0) begin bad++; $display("FAIL pause_resume got=%h/%b exp=00/0", Led, Tick); end
    edges(1);
    total++;
    if (Led !== 8'hFF || Tick !== 1'b1) begin bad++; $display("FAIL pause_step got=%h/%b exp=ff/1", Led, Tick); end
    edges(5);
    total++;
    if (Led !== 8'h00 || Tick !== 1'b1) begin bad++; $display("FAIL pause_next got=%h/%b exp=00/1", Led, Tick); end
  endtask

  task automatic test_collision_mode;
    do_reset(2'd1);
    edges(6);
    total++;
    if (Led !== 8'h02 || Tick !== 1'b1) begin bad++; $display("FAIL col_pre got=%h/%b exp=02/1", Led, Tick); end
    edges(4);
    Mode = 2'd2;
    edges(1);
    total++;
    if (Led !== 8'h01) begin bad++; $display("FAIL col_mode_led got=%h exp=01", Led); end
    total++;
    if (Tick !== 1'b0) begin bad++; $display("FAIL col_mode_tick got=%b exp=0", Tick); end
    edges(4);
    total++;
    if (Led !== 8'h01 || Tick !== 1'b0) begin bad++; $display("FAIL col_wait got=%h/%b exp=01/0", Led, Tick); end
    edges(1);
    total++;
    if (Led !== 8'h02 || Tick !== 1'b1) begin bad++; $display("FAIL col_next got=%h/%b exp=02/1", Led, Tick); end
  endtask

  task automatic test_reset_midrun;
    do_reset(2'd0);
    edges(9);
    total++;
    if (Led !== 8'hFF) begin bad++; $display("FAIL rst0_pre got=%h exp=ff", Led); end
    Reset = 1'b1;
    edges(1);
    total++;
    if (Led !== 8'h00 || Tick !== 1'b0) begin bad++; $display("FAIL rst0_edge got=%h/%b exp=00/0", Led, Tick); end
    Reset = 1'b0;
    edges(5);
    total++;
    if (Led !== 8'hFF || Tick !== 1'b1) begin bad++; $display("FAIL rst0_step got=%h/%b exp=ff/1", Led, Tick); end

    do_reset(2'd1);
    edges(8);
    total++;
    if (Led !== 8'h02) begin bad++; $display("FAIL rst1_pre got=%h exp=02", Led); end
    Reset = 1'b1;
    edges(1);
    total++;
    if (Led !== 8'h00 || Tick !== 1'b0) begin bad++; $display("FAIL rst1_edge got=%h/%b exp=00/0", Led, Tick); end
    Reset = 1'b0;
    edges(1);
    total++;
    if (Led !== 8'h01 || Tick !== 1'b0) begin bad++; $display("FAIL rst1_reload got=%h/%b exp=01/0", Led, Tick); end
    edges(5);
    total++;
    if (Led !== 8'h02 || Tick !== 1'b1) begin bad++; $display("FAIL rst1_step got=%h/%b exp=02/1", Led, Tick); end
  endtask

  task automatic test_back_to_back;
    do_reset(2'd0);
    Mode = 2'd1;
    edges(1);
    total++;
    if (Led !== 8'h01) begin bad++; $display("FAIL b2b_m1 got=%h exp=01", Led); end
    Mode = 2'd3;
    Pattern = 8'h3C;
    edges(1);
    total++;
    if (Led !== 8'h3C) begin bad++; $display("FAIL b2b_m3 got=%h exp=3c", Led); end
    Mode = 2'd0;
    edges(1);
    total++;
    if (Led !== 8'h00) begin bad++; $display("FAIL b2b_m0 got=%h exp=00", Led); end
    En = 1'b0;
    Mode = 2'd2;
    edges(1);
    total++;
    if (Led !== 8'h01 || Tick !== 1'b0) begin bad++; $display("FAIL b2b_dis got=%h/%b exp=01/0", Led, Tick); end
    edges(6);
    total++;
    if (Led !== 8'h01 || Tick !== 1'b0) begin bad++; $display("FAIL b2b_frozen got=%h/%b exp=01/0", Led, Tick); end
    En = 1'b1;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_running();
    test_pingpong();
    test_user();
    test_pause();
    test_collision_mode();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
